// File: rtl/mem_arb_pkg.sv
// Shared helpers for the memory-port arbiter: one-hot to index conversion.
package mem_arb_pkg;

    localparam int unsigned ARB_MAX_REQ = 32;

    // Valid only for one-hot or all-zero input; all-zero maps to index 0.
    function automatic int unsigned arb_onehot2idx(input logic [ARB_MAX_REQ-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem.sv
// Simple dual-port RAM, one write port and one registered read port.
// Same-address read and write in one cycle return the old word.
module mem #(
    parameter  int BITS  = 8,
    parameter  int WORDS = 16,
    localparam int ADDR  = $clog2(WORDS)
) (
    input  logic            clk,
    input  logic            w_enbl,
    input  logic [ADDR-1:0] w_addr,
    input  logic [BITS-1:0] w_data,
    input  logic [ADDR-1:0] r_addr,
    output logic [BITS-1:0] r_data
);

    logic [BITS-1:0] ram [WORDS];
    logic [BITS-1:0] r_data_q;

    // Contents are deliberately never reset so they survive a block reset.
    always_ff @(posedge clk) begin
        if (w_enbl) begin
            ram[w_addr] <= w_data;
        end
        r_data_q <= ram[r_addr];
    end

    assign r_data = r_data_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wraps mod N,
// and advances the pointer past the winner only when something is granted.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [IW:0] j;
        grant = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr_q} + (IW+1)'(k);
            if (j >= (IW+1)'(N)) begin
                j = j - (IW+1)'(N);
            end
            if (!any && req[j[IW-1:0]]) begin
                grant[j[IW-1:0]] = 1'b1;
                any              = 1'b1;
            end
        end
    end

    assign grant_idx = IW'(arb_onehot2idx(ARB_MAX_REQ'(grant)));

    always_comb begin
        ptr_d = ptr_q;
        if (any) begin
            ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one private dual-port RAM among NREQ requesters with independent
// round-robin arbitration of the write and read ports; reads return in one cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int BITS  = 8,
    parameter  int WORDS = 16,
    localparam int ADDR  = $clog2(WORDS),
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      wr_valid,
    input  logic [NREQ*ADDR-1:0] wr_addr,
    input  logic [NREQ*BITS-1:0] wr_data,
    output logic [NREQ-1:0]      wr_ready,
    input  logic [NREQ-1:0]      rd_valid,
    input  logic [NREQ*ADDR-1:0] rd_addr,
    output logic [NREQ-1:0]      rd_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_data
);

    logic [ADDR-1:0] wr_addr_a [NREQ];
    logic [BITS-1:0] wr_data_a [NREQ];
    logic [ADDR-1:0] rd_addr_a [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign wr_addr_a[gi] = wr_addr[gi*ADDR +: ADDR];
            assign wr_data_a[gi] = wr_data[gi*BITS +: BITS];
            assign rd_addr_a[gi] = rd_addr[gi*ADDR +: ADDR];
        end
    endgenerate

    logic [IDW-1:0] wr_idx, rd_idx;
    logic           wr_any, rd_any;

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (wr_valid),
        .grant     (wr_ready),
        .grant_idx (wr_idx),
        .any       (wr_any)
    );

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rd_valid),
        .grant     (rd_ready),
        .grant_idx (rd_idx),
        .any       (rd_any)
    );

    logic            w_enbl;
    logic [ADDR-1:0] w_addr;
    logic [BITS-1:0] w_data;
    logic [ADDR-1:0] r_addr;
    logic [BITS-1:0] r_data;

    always_comb begin
        w_enbl = wr_any;
        w_addr = wr_addr_a[wr_idx];
        w_data = wr_data_a[wr_idx];
        r_addr = rd_addr_a[rd_idx];
    end

    mem #(.BITS(BITS), .WORDS(WORDS)) u_mem (
        .clk    (clk),
        .w_enbl (w_enbl),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    always_comb begin
        rsp_valid_d = rd_any;
        rsp_id_d    = rd_any ? rd_idx : rsp_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // The RAM output register is not reset, so gate the data with valid.
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_valid_q ? r_data : '0;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(wr_ready) && $onehot0(rd_ready));
    a_grant_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        ((wr_ready & ~wr_valid) == '0) && ((rd_ready & ~rd_valid) == '0));
    a_rsp_after_grant: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> $past(rd_any));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural reference model.
module tb_mem_port_arbiter;

    localparam int NREQ  = 4;
    localparam int BITS  = 8;
    localparam int WORDS = 16;
    localparam int ADDR  = 4;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      wr_valid;
    logic [NREQ*ADDR-1:0] wr_addr;
    logic [NREQ*BITS-1:0] wr_data;
    logic [NREQ-1:0]      wr_ready;
    logic [NREQ-1:0]      rd_valid;
    logic [NREQ*ADDR-1:0] rd_addr;
    logic [NREQ-1:0]      rd_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NREQ(NREQ), .BITS(BITS), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    // Requester-side state: each request is held until the model says it was granted.
    bit   [NREQ-1:0] wv, rv;
    logic [ADDR-1:0] wa [NREQ];
    logic [ADDR-1:0] ra [NREQ];
    logic [BITS-1:0] wd [NREQ];

    // Reference model: memory image, round-robin pointers, expected responses.
    logic [BITS-1:0] mm [WORDS];
    int wp, rp;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [BITS-1:0] data;
    } rsp_t;
    rsp_t sbq [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic int rr_pick(input bit [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            wr_valid[i]               = wv[i];
            rd_valid[i]               = rv[i];
            wr_addr[i*ADDR +: ADDR]   = wa[i];
            wr_data[i*BITS +: BITS]   = wd[i];
            rd_addr[i*ADDR +: ADDR]   = ra[i];
        end
    endtask

    task automatic refill_w(input int i);
        if (!wv[i]) begin
            wv[i] = 1'b1;
            wa[i] = ADDR'($urandom_range(WORDS-1, 0));
            wd[i] = BITS'($urandom);
        end
    endtask

    task automatic refill_r(input int i);
        if (!rv[i]) begin
            rv[i] = 1'b1;
            ra[i] = ADDR'($urandom_range(WORDS-1, 0));
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Called at a negedge: drive held requests, check grants against the model,
    // update the model, then advance to the next negedge.
    task automatic drive_cycle(input int fix_w, input int fix_r);
        int ew, er;
        logic [NREQ-1:0] exp_w, exp_r;
        rsp_t e;
        pack();
        #1;
        ew = rr_pick(wv, wp);
        er = rr_pick(rv, rp);
        exp_w = '0;
        exp_r = '0;
        if (ew >= 0) exp_w[ew] = 1'b1;
        if (er >= 0) exp_r[er] = 1'b1;
        check_eq("wr_ready", 32'(wr_ready), 32'(exp_w));
        check_eq("rd_ready", 32'(rd_ready), 32'(exp_r));
        if (fix_w >= 0) check_eq("wr_grant_order", 32'(wr_ready), 32'(1) << fix_w);
        if (fix_r >= 0) check_eq("rd_grant_order", 32'(rd_ready), 32'(1) << fix_r);
        if (er >= 0) begin
            e.id   = IDW'(er);
            e.data = mm[ra[er]];
            sbq.push_back(e);
            $display("cycle %0d read  grant id=%0d addr=%0d", cyc, er, ra[er]);
            rv[er] = 1'b0;
            rp = (er + 1) % NREQ;
        end
        if (ew >= 0) begin
            mm[wa[ew]] = wd[ew];
            $display("cycle %0d write grant id=%0d addr=%0d data=%02h", cyc, ew, wa[ew], wd[ew]);
            wv[ew] = 1'b0;
            wp = (ew + 1) % NREQ;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Monitor: response register is stable at the negedge.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d data=%02h, required no response", rsp_id, rsp_data);
                end else begin
                    r = sbq.pop_front();
                    if (rsp_id !== r.id || rsp_data !== r.data) begin
                        errors++;
                        $display("FAIL rsp: got id=%0d data=%02h required id=%0d data=%02h",
                                 rsp_id, rsp_data, r.id, r.data);
                    end else begin
                        $display("response id=%0d data=%02h", rsp_id, rsp_data);
                    end
                end
            end else begin
                checks++;
                if (rsp_data !== '0 || sbq.size() != 0) begin
                    errors++;
                    $display("FAIL rsp_idle: got valid=%b data=%02h pending=%0d, required data=00 pending=0",
                             rsp_valid, rsp_data, sbq.size());
                    if (sbq.size() != 0) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wv = '0;
        rv = '0;
        wp = 0;
        rp = 0;
        for (int i = 0; i < NREQ; i++) begin
            wa[i] = '0;
            ra[i] = '0;
            wd[i] = '0;
        end
        pack();

        // Reset, no requests
        @(negedge clk);
        #1;
        check_eq("reset_wr_ready", 32'(wr_ready), 0);
        check_eq("reset_rd_ready", 32'(rd_ready), 0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 0);
        check_eq("reset_rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All writers held valid: grants rotate 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) refill_w(i);
            drive_cycle(k % NREQ, -1);
        end
        wv = '0;

        // Fill every word so later reads have known contents
        for (int a = 0; a < WORDS; a++) begin
            wv[0] = 1'b1;
            wa[0] = ADDR'(a);
            wd[0] = BITS'($urandom);
            drive_cycle(-1, -1);
        end

        // Requester 1 writes A5 to 3, reads it back two cycles later
        wv[1] = 1'b1; wa[1] = 4'd3; wd[1] = 8'hA5;
        drive_cycle(-1, -1);
        drive_cycle(-1, -1);
        rv[1] = 1'b1; ra[1] = 4'd3;
        drive_cycle(-1, -1);
        check_eq("t2_rsp_valid", 32'(rsp_valid), 1);
        check_eq("t2_rsp_id", 32'(rsp_id), 1);
        check_eq("t2_rsp_data", 32'(rsp_data), 32'h A5);

        // Same-address read and write in one cycle return the old word
        wv[2] = 1'b1; wa[2] = 4'd5; wd[2] = 8'h11;
        drive_cycle(-1, -1);
        wv[0] = 1'b1; wa[0] = 4'd5; wd[0] = 8'h22;
        rv[3] = 1'b1; ra[3] = 4'd5;
        drive_cycle(-1, -1);
        check_eq("t4_old_word", 32'(rsp_data), 32'h11);
        rv[1] = 1'b1; ra[1] = 4'd5;
        drive_cycle(-1, -1);
        check_eq("t4_new_word", 32'(rsp_data), 32'h22);

        // Read pointer at 2, only 0 and 3 requesting: 3 wins, then 0
        rv[1] = 1'b1; ra[1] = 4'd0;
        drive_cycle(-1, 1);
        rv[0] = 1'b1; ra[0] = 4'd1;
        rv[3] = 1'b1; ra[3] = 4'd2;
        drive_cycle(-1, 3);
        drive_cycle(-1, 0);

        // Reset while a response is pending
        rv[2] = 1'b1; ra[2] = 4'd7;
        pack();
        @(posedge clk);
        #2;
        check_eq("t6_rsp_pending", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        wv = '0;
        rv = '0;
        pack();
        wp = 0;
        rp = 0;
        #1;
        check_eq("t6_rsp_dropped", 32'(rsp_valid), 0);
        check_eq("t6_rsp_data_zero", 32'(rsp_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            refill_w(i);
            refill_r(i);
        end
        drive_cycle(0, 0);
        wv = '0;
        rv = '0;
        rv[2] = 1'b1; ra[2] = 4'd3;
        drive_cycle(-1, -1);
        check_eq("t6_ram_kept", 32'(rsp_data), 32'h A5);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(1, 0) == 1) refill_w(i);
                if ($urandom_range(1, 0) == 1) refill_r(i);
            end
            drive_cycle(-1, -1);
        end
        // Drain held requests, then idle
        for (int n = 0; n < 2 * NREQ; n++) drive_cycle(-1, -1);
        for (int n = 0; n < 3; n++) drive_cycle(-1, -1);

        check_eq("scoreboard_empty", 32'(sbq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
